// File: rtl/ddr_out_serializer.sv
// DDR output serializer: words queue in a FIFO, then each is shifted out two bits
// per ce-cycle per channel on d0/d1, with q muxing them by clk for the pad.
module ddr_out_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CHANNELS  = 1,
  parameter int unsigned DEPTH     = 4,
  parameter bit          IDLE      = 1'b0,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*WIDTH-1:0]    in_data,
  input  logic                         in_last,
  output logic [CHANNELS-1:0]          d0,
  output logic [CHANNELS-1:0]          d1,
  output logic [CHANNELS-1:0]          q,
  output logic                         busy,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         underrun
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned DW    = CHANNELS * WIDTH;
  localparam int unsigned BEATS = WIDTH / 2;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [CHANNELS-1:0] IDLE_VEC = {CHANNELS{IDLE}};

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  // FIFO storage and pointers
  logic [DW:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;

  // Shifter state
  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [DW-1:0]   sr_q, sr_d;
  logic            last_q, last_d;
  logic [CHANNELS-1:0] d0_q, d0_d;
  logic [CHANNELS-1:0] d1_q, d1_d;
  logic            underrun_q, underrun_d;

  logic            push, pop, empty, full;
  logic [DW:0]     fifo_head;
  logic [DW-1:0]   fifo_word, fifo_rest, sr_rest;
  logic            fifo_last;
  logic [CHANNELS-1:0] fifo_h0, fifo_h1, sr_h0, sr_h1;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign in_ready  = ~full & ~reset;
  assign push      = in_valid & in_ready;
  assign fifo_head = mem_q[rd_ptr_q];
  assign fifo_word = fifo_head[DW-1:0];
  assign fifo_last = fifo_head[DW];

  // Per-lane pair extraction: sr_q always holds the not-yet-shown pairs at the
  // leading end of each lane, so only constant bit positions are ever read.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic [WIDTH-1:0] f_lane, s_lane;
    assign f_lane = fifo_word[c*WIDTH +: WIDTH];
    assign s_lane = sr_q[c*WIDTH +: WIDTH];
    if (MSB_FIRST) begin : g_msb
      assign fifo_h0[c] = f_lane[WIDTH-1];
      assign fifo_h1[c] = f_lane[WIDTH-2];
      assign sr_h0[c]   = s_lane[WIDTH-1];
      assign sr_h1[c]   = s_lane[WIDTH-2];
      assign fifo_rest[c*WIDTH +: WIDTH] = f_lane << 2;
      assign sr_rest[c*WIDTH +: WIDTH]   = s_lane << 2;
    end else begin : g_lsb
      assign fifo_h0[c] = f_lane[0];
      assign fifo_h1[c] = f_lane[1];
      assign sr_h0[c]   = s_lane[0];
      assign sr_h1[c]   = s_lane[1];
      assign fifo_rest[c*WIDTH +: WIDTH] = f_lane >> 2;
      assign sr_rest[c*WIDTH +: WIDTH]   = s_lane >> 2;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    sr_d       = sr_q;
    last_d     = last_q;
    d0_d       = d0_q;
    d1_d       = d1_q;
    underrun_d = underrun_q;
    pop        = 1'b0;

    if (ce) begin
      if (state_q == S_IDLE || beat_q == BEAT_LAST) begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_SHIFT;
          beat_d  = '0;
          sr_d    = fifo_rest;
          last_d  = fifo_last;
          d0_d    = fifo_h0;
          d1_d    = fifo_h1;
        end else if (state_q == S_SHIFT) begin
          state_d = S_IDLE;
          beat_d  = '0;
          d0_d    = IDLE_VEC;
          d1_d    = IDLE_VEC;
          if (!last_q) begin
            underrun_d = 1'b1;
          end
        end
      end else begin
        beat_d = beat_q + 1'b1;
        sr_d   = sr_rest;
        d0_d   = sr_h0;
        d1_d   = sr_h1;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_last, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      beat_q     <= '0;
      sr_q       <= '0;
      last_q     <= 1'b0;
      d0_q       <= IDLE_VEC;
      d1_q       <= IDLE_VEC;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      beat_q     <= beat_d;
      sr_q       <= sr_d;
      last_q     <= last_d;
      d0_q       <= d0_d;
      d1_q       <= d1_d;
      underrun_q <= underrun_d;
    end
  end

  assign d0       = d0_q;
  assign d1       = d1_q;
  assign q        = clk ? d0_q : d1_q;
  assign busy     = (state_q == S_SHIFT);
  assign level    = count_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_ddr_out_serializer.sv
// Bench for ddr_out_serializer: per-cycle vector table on the default build,
// plus directed sequences for FIFO-full streaming and a two-lane LSB-first build.
module tb_ddr_out_serializer;

  logic       clk;
  logic       reset, ce;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_data;
  logic [0:0] d0, d1, q;
  logic       busy, underrun;
  logic [2:0] level;

  logic        v7, rdy7, last7, busy7, und7;
  logic [15:0] data7;
  logic [1:0]  d0_7, d1_7, q_7;
  logic [2:0]  level7;

  int n_cmp = 0;
  int n_bad = 0;

  ddr_out_serializer u_dut (
    .clk(clk), .reset(reset), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .d0(d0), .d1(d1), .q(q), .busy(busy), .level(level), .underrun(underrun)
  );

  ddr_out_serializer #(.CHANNELS(2), .MSB_FIRST(1'b0)) u_dut2 (
    .clk(clk), .reset(reset), .ce(ce),
    .in_valid(v7), .in_ready(rdy7), .in_data(data7), .in_last(last7),
    .d0(d0_7), .d1(d1_7), .q(q_7), .busy(busy7), .level(level7), .underrun(und7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst, ce, v;
    logic [7:0] data;
    logic       last;
    logic       e_d0, e_d1, e_busy;
    logic [2:0] e_lvl;
    logic       e_rdy, e_und;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic c, input logic v, input logic [7:0] dat,
                     input logic lst, input logic e0, input logic e1, input logic eb,
                     input logic [2:0] el, input logic er, input logic eu);
    vec_t r;
    r.rst = rst; r.ce = c; r.v = v; r.data = dat; r.last = lst;
    r.e_d0 = e0; r.e_d1 = e1; r.e_busy = eb; r.e_lvl = el; r.e_rdy = er; r.e_und = eu;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] words [5];
  logic [7:0] w, sh;
  logic       e0, e1, acc, will_acc;
  logic [1:0] e7_d0 [4];
  logic [1:0] e7_d1 [4];

  initial begin
    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    v7 = 1'b0; data7 = '0; last7 = 1'b0;

    //   rst ce v  data  last  d0 d1 busy lvl rdy und
    add(1, 1, 0, 8'h00, 0,    0, 0, 0,   0,  0,  0);
    add(0, 1, 0, 8'h00, 0,    0, 0, 0,   0,  1,  0);
    // single word 0xA5
    add(0, 1, 1, 8'hA5, 1,    0, 0, 0,   1,  1,  0);
    add(0, 1, 0, 8'h00, 0,    1, 0, 1,   0,  1,  0);
    add(0, 1, 0, 8'h00, 0,    1, 0, 1,   0,  1,  0);
    add(0, 1, 0, 8'h00, 0,    0, 1, 1,   0,  1,  0);
    add(0, 1, 0, 8'h00, 0,    0, 1, 1,   0,  1,  0);
    add(0, 1, 0, 8'h00, 0,    0, 0, 0,   0,  1,  0);
    // 0xFF then 0x00 back-to-back
    add(0, 1, 1, 8'hFF, 0,    0, 0, 0,   1,  1,  0);
    add(0, 1, 1, 8'h00, 1,    1, 1, 1,   1,  1,  0);
    add(0, 1, 0, 8'h00, 0,    1, 1, 1,   1,  1,  0);
    add(0, 1, 0, 8'h00, 0,    1, 1, 1,   1,  1,  0);
    add(0, 1, 0, 8'h00, 0,    1, 1, 1,   1,  1,  0);
    add(0, 1, 0, 8'h00, 0,    0, 0, 1,   0,  1,  0);
    add(0, 1, 0, 8'h00, 0,    0, 0, 1,   0,  1,  0);
    add(0, 1, 0, 8'h00, 0,    0, 0, 1,   0,  1,  0);
    add(0, 1, 0, 8'h00, 0,    0, 0, 1,   0,  1,  0);
    add(0, 1, 0, 8'h00, 0,    0, 0, 0,   0,  1,  0);
    // 0xA5 with ce toggling every cycle
    add(0, 1, 1, 8'hA5, 1,    0, 0, 0,   1,  1,  0);
    add(0, 1, 0, 8'h00, 0,    1, 0, 1,   0,  1,  0);
    add(0, 0, 0, 8'h00, 0,    1, 0, 1,   0,  1,  0);
    add(0, 1, 0, 8'h00, 0,    1, 0, 1,   0,  1,  0);
    add(0, 0, 0, 8'h00, 0,    1, 0, 1,   0,  1,  0);
    add(0, 1, 0, 8'h00, 0,    0, 1, 1,   0,  1,  0);
    add(0, 0, 0, 8'h00, 0,    0, 1, 1,   0,  1,  0);
    add(0, 1, 0, 8'h00, 0,    0, 1, 1,   0,  1,  0);
    add(0, 0, 0, 8'h00, 0,    0, 1, 1,   0,  1,  0);
    add(0, 1, 0, 8'h00, 0,    0, 0, 0,   0,  1,  0);
    // 0x3C without last -> underrun, sticky
    add(0, 1, 1, 8'h3C, 0,    0, 0, 0,   1,  1,  0);
    add(0, 1, 0, 8'h00, 0,    0, 0, 1,   0,  1,  0);
    add(0, 1, 0, 8'h00, 0,    1, 1, 1,   0,  1,  0);
    add(0, 1, 0, 8'h00, 0,    1, 1, 1,   0,  1,  0);
    add(0, 1, 0, 8'h00, 0,    0, 0, 1,   0,  1,  0);
    add(0, 1, 0, 8'h00, 0,    0, 0, 0,   0,  1,  1);
    add(0, 1, 0, 8'h00, 0,    0, 0, 0,   0,  1,  1);
    add(0, 0, 0, 8'h00, 0,    0, 0, 0,   0,  1,  1);
    // reset on beat 2 with a word queued behind
    add(0, 1, 1, 8'hA5, 0,    0, 0, 0,   1,  1,  1);
    add(0, 1, 0, 8'h00, 0,    1, 0, 1,   0,  1,  1);
    add(0, 1, 1, 8'h77, 1,    1, 0, 1,   1,  1,  1);
    add(0, 1, 0, 8'h00, 0,    0, 1, 1,   1,  1,  1);
    add(1, 1, 0, 8'h00, 0,    0, 0, 0,   0,  0,  0);
    add(0, 1, 0, 8'h00, 0,    0, 0, 0,   0,  1,  0);
    add(0, 1, 0, 8'h00, 0,    0, 0, 0,   0,  1,  0);

    foreach (tbl[i]) begin
      reset = tbl[i].rst; ce = tbl[i].ce; in_valid = tbl[i].v;
      in_data = tbl[i].data; in_last = tbl[i].last;
      tick();
      chk($sformatf("vec%0d {d0,d1,q,busy,level,ready,underrun}", i),
          {24'd0, d0, d1, q, busy, level, in_ready, underrun},
          {24'd0, tbl[i].e_d0, tbl[i].e_d1, tbl[i].e_d0, tbl[i].e_busy,
           tbl[i].e_lvl, tbl[i].e_rdy, tbl[i].e_und});
    end
    in_valid = 1'b0;

    // FIFO fill with ce held low, then a 20-beat contiguous stream
    words[0] = 8'h81; words[1] = 8'h42; words[2] = 8'h24; words[3] = 8'h18; words[4] = 8'hC3;
    ce = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = words[i]; in_last = 1'b0;
      tick();
    end
    chk("fill4 {level,ready}", {28'd0, level, in_ready}, {28'd0, 3'd4, 1'b0});
    in_data = words[4]; in_last = 1'b1;
    tick();
    chk("full_hold {level,ready,busy}", {27'd0, level, in_ready, busy}, {27'd0, 3'd4, 1'b0, 1'b0});
    ce = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 20; n++) begin
      will_acc = in_valid & in_ready;
      tick();
      if (will_acc) begin
        in_valid = 1'b0;
        acc = 1'b1;
      end
      w  = words[n / 4];
      sh = w << (2 * (n % 4));
      e0 = sh[7];
      e1 = sh[6];
      chk($sformatf("stream beat%0d {d0,d1,q,busy}", n), {28'd0, d0, d1, q, busy},
          {28'd0, e0, e1, e0, 1'b1});
      if (n == 0) chk("no_anticipate level", {29'd0, level}, {29'd0, 3'd3});
      if (n == 1) chk("refill level", {29'd0, level}, {29'd0, 3'd4});
      #5;
      chk($sformatf("stream beat%0d q_low", n), {31'd0, q}, {31'd0, e1});
    end
    tick();
    chk("stream end {d0,d1,busy,level,underrun}", {26'd0, d0, d1, busy, level, underrun},
        {26'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0});
    chk("fifth word accepted", {31'd0, acc}, 32'd1);

    // two lanes, LSB first
    e7_d0[0] = 2'b10; e7_d0[1] = 2'b00; e7_d0[2] = 2'b00; e7_d0[3] = 2'b00;
    e7_d1[0] = 2'b00; e7_d1[1] = 2'b00; e7_d1[2] = 2'b00; e7_d1[3] = 2'b01;
    v7 = 1'b1; data7 = {8'h01, 8'h80}; last7 = 1'b1;
    tick();
    v7 = 1'b0;
    chk("ch2 pushed {level,busy}", {28'd0, level7, busy7}, {28'd0, 3'd1, 1'b0});
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("ch2 beat%0d {d0,d1,busy}", k), {27'd0, d0_7, d1_7, busy7},
          {27'd0, e7_d0[k], e7_d1[k], 1'b1});
    end
    tick();
    chk("ch2 end {d0,d1,busy,underrun}", {26'd0, d0_7, d1_7, busy7, und7}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
